// File: rtl/gate_tester2.sv
// gate_tester2: walks all four input vectors of a 2-input gate and checks z0 against TRUTH.
module gate_tester2 #(
  parameter int         SETTLE = 2,
  parameter logic [3:0] TRUTH  = 4'b1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       z0,
  output logic       x0,
  output logic       x1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] first_fail
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  localparam int HW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  state_t r_state, w_next;
  logic [HW-1:0] r_hold;
  logic [1:0] r_vec;
  logic w_last, w_miss;
  logic [2:0] w_err;
  assign w_last = (r_state == RUN) && (r_hold == HW'(SETTLE));
  assign w_miss = w_last && (z0 != TRUTH[r_vec]);
  assign w_err  = err_cnt + {2'b00, w_miss};
  assign busy   = r_state == RUN;
  assign done   = r_state == FINISH;
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE ? (start ? RUN : IDLE) :
             r_state == RUN  ? ((w_last && r_vec == 2'd3) ? FINISH : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else r_state <= w_next;
  // r_vec wraps 3->0 on the final sample, which also returns the gate inputs to 00
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_hold     <= '0;
      r_vec      <= '0;
      {x1, x0}   <= '0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else if (r_state == IDLE && start) begin
      r_hold     <= '0;
      r_vec      <= '0;
      {x1, x0}   <= '0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else if (r_state == RUN) begin
      if (w_last) begin
        r_hold   <= '0;
        r_vec    <= r_vec + 2'd1;
        {x1, x0} <= r_vec + 2'd1;
        err_cnt  <= w_err;
        if (w_miss && err_cnt == 3'd0) first_fail <= r_vec;
        if (r_vec == 2'd3) pass <= (w_err == 3'd0);
      end else r_hold <= r_hold + 1'b1;
    end
endmodule

// File: tb/tb_gate_tester2.sv
// tb_gate_tester2: directed runs against AND/stuck/OR/XOR gate models with hand-derived results.
module tb_gate_tester2;
  logic clk = 1'b0, rstn = 1'b0;
  logic [2:0] st = '0;
  logic [1:0] mode = '0;
  int sel = 0;
  int checks = 0, failures = 0;
  logic xa0, xa1, ba, da, pa, za;
  logic xx0, xx1, bx, dx, px, zx;
  logic xf0, xf1, bf, df, pf, zf;
  logic [2:0] ea, ex, ef;
  logic [1:0] fa, fx, ff;
  logic [1:0] ox, of;
  logic ob, od, op;
  logic [2:0] oe;
  always #5 clk = ~clk;
  assign za = mode == 2'd0 ? (xa0 & xa1) : mode == 2'd1 ? 1'b0 : mode == 2'd2 ? 1'b1 : (xa0 | xa1);
  assign zx = xx0 ^ xx1;
  assign zf = xf0 & xf1;
  gate_tester2 u_a (.clk(clk), .rstn(rstn), .start(st[0]), .z0(za), .x0(xa0), .x1(xa1),
    .busy(ba), .done(da), .pass(pa), .err_cnt(ea), .first_fail(fa));
  gate_tester2 #(.SETTLE(2), .TRUTH(4'b0110)) u_x (.clk(clk), .rstn(rstn), .start(st[1]), .z0(zx),
    .x0(xx0), .x1(xx1), .busy(bx), .done(dx), .pass(px), .err_cnt(ex), .first_fail(fx));
  gate_tester2 #(.SETTLE(0)) u_f (.clk(clk), .rstn(rstn), .start(st[2]), .z0(zf), .x0(xf0), .x1(xf1),
    .busy(bf), .done(df), .pass(pf), .err_cnt(ef), .first_fail(ff));
  always_comb begin
    ox = sel == 0 ? {xa1, xa0} : sel == 1 ? {xx1, xx0} : {xf1, xf0};
    ob = sel == 0 ? ba : sel == 1 ? bx : bf;
    od = sel == 0 ? da : sel == 1 ? dx : df;
    op = sel == 0 ? pa : sel == 1 ? px : pf;
    oe = sel == 0 ? ea : sel == 1 ? ex : ef;
    of = sel == 0 ? fa : sel == 1 ? fx : ff;
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, " x"}, 32'(ox), 0);
    chk({tag, " busy"}, 32'(ob), 0);
    chk({tag, " done"}, 32'(od), 0);
    chk({tag, " pass"}, 32'(op), 0);
    chk({tag, " err"}, 32'(oe), 0);
    chk({tag, " ff"}, 32'(of), 0);
  endtask
  // k counts edges after the accepting edge T0; vector k/(settle+1) is on the pins during cycle k
  task automatic run(input int s, input int settle, input bit rep, input int ep, input int ee, input int eff);
    int n;
    n = 4 * (settle + 1);
    sel = s;
    @(negedge clk) st[s] = 1'b1;
    @(negedge clk) st[s] = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (rep && k == 4) st[s] = 1'b1;
      if (rep && k == 5) st[s] = 1'b0;
      chk($sformatf("d%0d x k=%0d", s, k), 32'(ox), k < n ? k / (settle + 1) : 0);
      chk($sformatf("d%0d busy k=%0d", s, k), 32'(ob), 32'(k < n));
      chk($sformatf("d%0d done k=%0d", s, k), 32'(od), 32'(k == n));
    end
    chk($sformatf("d%0d pass", s), 32'(op), ep);
    chk($sformatf("d%0d err_cnt", s), 32'(oe), ee);
    chk($sformatf("d%0d first_fail", s), 32'(of), eff);
  endtask
  initial begin
    int dones;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rstn = 1'b1;
    mode = 2'd0; run(0, 2, 1'b0, 1, 0, 0);
    mode = 2'd1; run(0, 2, 1'b0, 0, 1, 3);
    mode = 2'd2; run(0, 2, 1'b1, 0, 3, 0);
    mode = 2'd3; run(0, 2, 1'b0, 0, 2, 1);
    run(1, 2, 1'b0, 1, 0, 0);
    run(2, 0, 1'b0, 1, 0, 0);
    mode = 2'd2; sel = 0;
    @(negedge clk) st[0] = 1'b1;
    @(negedge clk) st[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset err", 32'(oe), 1);
    rstn = 1'b0;
    #1 chk_idle("async reset");
    @(negedge clk) rstn = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (od) dones++;
    end
    chk("no done after reset", 32'(dones), 0);
    mode = 2'd0; run(0, 2, 1'b0, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
